// File: rtl/vga_pattern_gen.sv
// Parametrised VGA timing and test-pattern generator. Every output is registered on the
// pixel enable that follows the h/v counter state it describes, so sync, blank, X/Y and RGB stay aligned.
`timescale 1ns/1ps
module vga_pattern_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter int   CLK_DIV  = 2,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   COLOR_W  = 8,
    localparam int  H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int  V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int  XW       = $clog2(H_TOTAL),
    localparam int  YW       = $clog2(V_TOTAL)
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               i_En,
    input  logic [1:0]         i_Mode,
    input  logic [1:0]         i_ColorSel,
    output logic               o_PixEn,
    output logic               o_Hsync,
    output logic               o_Vsync,
    output logic               o_Blank_n,
    output logic               o_Frame,
    output logic [XW-1:0]      o_X,
    output logic [YW-1:0]      o_Y,
    output logic [COLOR_W-1:0] o_Red,
    output logic [COLOR_W-1:0] o_Green,
    output logic [COLOR_W-1:0] o_Blue
);

    localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BAR_W    = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    logic [DW-1:0]      div_r;
    logic [XW-1:0]      h_r;
    logic [YW-1:0]      v_r;
    logic [1:0]         mode_r;
    logic [1:0]         color_r;

    logic               last_div_s;
    logic               pix_en_s;
    logic               frame_start_s;
    logic               active_s;
    logic               hs_on_s;
    logic               vs_on_s;
    logic [1:0]         mode_s;
    logic [1:0]         color_s;
    logic [XW-1:0]      bar_q_s;
    logic [2:0]         bar_idx_s;
    logic               checker_s;
    logic [COLOR_W-1:0] red_s;
    logic [COLOR_W-1:0] green_s;
    logic [COLOR_W-1:0] blue_s;

    function automatic logic [2:0] solid_rgb(input logic [1:0] sel);
        case (sel)
            2'd0:    solid_rgb = 3'b100;
            2'd1:    solid_rgb = 3'b010;
            2'd2:    solid_rgb = 3'b001;
            2'd3:    solid_rgb = 3'b111;
            default: solid_rgb = 3'b111;
        endcase
    endfunction

    // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_rgb = 3'b111;
            3'd1:    bar_rgb = 3'b110;
            3'd2:    bar_rgb = 3'b011;
            3'd3:    bar_rgb = 3'b010;
            3'd4:    bar_rgb = 3'b101;
            3'd5:    bar_rgb = 3'b100;
            3'd6:    bar_rgb = 3'b001;
            3'd7:    bar_rgb = 3'b000;
            default: bar_rgb = 3'b000;
        endcase
    endfunction

    function automatic logic [COLOR_W-1:0] chan(input logic on);
        chan = on ? {COLOR_W{1'b1}} : {COLOR_W{1'b0}};
    endfunction

    // Timing decode of the current counter state.
    always_comb begin
        last_div_s    = (div_r == DW'(CLK_DIV - 1));
        pix_en_s      = i_En && last_div_s;
        frame_start_s = (h_r == {XW{1'b0}}) && (v_r == {YW{1'b0}});
        active_s      = (h_r < XW'(H_ACTIVE)) && (v_r < YW'(V_ACTIVE));
        hs_on_s       = (h_r >= XW'(HS_START)) && (h_r <= XW'(HS_END - 1));
        vs_on_s       = (v_r >= YW'(VS_START)) && (v_r <= YW'(VS_END - 1));
        // The frame's first pixel already uses the freshly sampled selection.
        mode_s        = frame_start_s ? i_Mode : mode_r;
        color_s       = frame_start_s ? i_ColorSel : color_r;
    end

    // Pattern colour for the current counter position.
    always_comb begin
        bar_q_s   = h_r / XW'(BAR_W);
        bar_idx_s = (bar_q_s > XW'(7)) ? 3'd7 : bar_q_s[2:0];
        checker_s = ((h_r & XW'(32)) != {XW{1'b0}}) ^ ((v_r & YW'(32)) != {YW{1'b0}});
        red_s     = {COLOR_W{1'b0}};
        green_s   = {COLOR_W{1'b0}};
        blue_s    = {COLOR_W{1'b0}};
        if (active_s) begin
            case (mode_s)
                2'd0: begin
                    red_s   = chan(solid_rgb(color_s)[2]);
                    green_s = chan(solid_rgb(color_s)[1]);
                    blue_s  = chan(solid_rgb(color_s)[0]);
                end
                2'd1: begin
                    red_s   = chan(bar_rgb(bar_idx_s)[2]);
                    green_s = chan(bar_rgb(bar_idx_s)[1]);
                    blue_s  = chan(bar_rgb(bar_idx_s)[0]);
                end
                2'd2: begin
                    red_s   = chan(checker_s);
                    green_s = chan(checker_s);
                    blue_s  = chan(checker_s);
                end
                2'd3: begin
                    red_s   = COLOR_W'(h_r);
                    green_s = COLOR_W'(v_r);
                    blue_s  = COLOR_W'(h_r) + COLOR_W'(v_r);
                end
                default: begin
                    red_s   = {COLOR_W{1'b0}};
                    green_s = {COLOR_W{1'b0}};
                    blue_s  = {COLOR_W{1'b0}};
                end
            endcase
        end else begin
            red_s   = {COLOR_W{1'b0}};
            green_s = {COLOR_W{1'b0}};
            blue_s  = {COLOR_W{1'b0}};
        end
    end

    // Clock divider, h/v counters and per-frame mode latch.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            div_r   <= {DW{1'b0}};
            h_r     <= {XW{1'b0}};
            v_r     <= {YW{1'b0}};
            mode_r  <= 2'd0;
            color_r <= 2'd0;
        end else if (!i_En) begin
            div_r   <= {DW{1'b0}};
            h_r     <= {XW{1'b0}};
            v_r     <= {YW{1'b0}};
            mode_r  <= 2'd0;
            color_r <= 2'd0;
        end else begin
            div_r <= last_div_s ? {DW{1'b0}} : div_r + DW'(1);
            if (pix_en_s) begin
                mode_r  <= mode_s;
                color_r <= color_s;
                if (h_r == XW'(H_TOTAL - 1)) begin
                    h_r <= {XW{1'b0}};
                    v_r <= (v_r == YW'(V_TOTAL - 1)) ? {YW{1'b0}} : v_r + YW'(1);
                end else begin
                    h_r <= h_r + XW'(1);
                end
            end
        end
    end

    // Registered video outputs, updated only on the pixel enable.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            o_PixEn   <= 1'b0;
            o_Hsync   <= ~HS_POL;
            o_Vsync   <= ~VS_POL;
            o_Blank_n <= 1'b0;
            o_Frame   <= 1'b0;
            o_X       <= {XW{1'b0}};
            o_Y       <= {YW{1'b0}};
            o_Red     <= {COLOR_W{1'b0}};
            o_Green   <= {COLOR_W{1'b0}};
            o_Blue    <= {COLOR_W{1'b0}};
        end else if (!i_En) begin
            o_PixEn   <= 1'b0;
            o_Hsync   <= ~HS_POL;
            o_Vsync   <= ~VS_POL;
            o_Blank_n <= 1'b0;
            o_Frame   <= 1'b0;
            o_X       <= {XW{1'b0}};
            o_Y       <= {YW{1'b0}};
            o_Red     <= {COLOR_W{1'b0}};
            o_Green   <= {COLOR_W{1'b0}};
            o_Blue    <= {COLOR_W{1'b0}};
        end else begin
            o_PixEn <= pix_en_s;
            if (pix_en_s) begin
                o_Hsync   <= hs_on_s ? HS_POL : ~HS_POL;
                o_Vsync   <= vs_on_s ? VS_POL : ~VS_POL;
                o_Blank_n <= active_s;
                o_Frame   <= frame_start_s;
                o_Red     <= red_s;
                o_Green   <= green_s;
                o_Blue    <= blue_s;
                if (active_s) begin
                    o_X <= h_r;
                    o_Y <= v_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen on a reduced raster; expected pixels come from
// the raster position (pixel number modulo frame size) and the pattern rules.
`timescale 1ns/1ps
module tb_vga_pattern_gen;
    localparam int HA = 84, HFP = 4, HSY = 6, HBP = 6;
    localparam int VA = 40, VFP = 2, VSY = 2, VBP = 3;
    localparam int CD = 2, CW = 6;
    localparam logic HSP = 1'b1, VSP = 1'b0;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FRAME = HT * VT;
    localparam int FCYC = FRAME * CD;
    localparam int XW = $clog2(HT), YW = $clog2(VT);
    localparam int OW = 4 + XW + YW + 3 * CW;
    localparam int NF = 5;
    localparam logic [OW-1:0] IDLE = {~HSP, ~VSP, 2'b00, {(OW-4){1'b0}}};

    logic Clk = 1'b0;
    logic Rst_n, i_En;
    logic [1:0] i_Mode, i_ColorSel;
    logic o_PixEn, o_Hsync, o_Vsync, o_Blank_n, o_Frame;
    logic [XW-1:0] o_X;
    logic [YW-1:0] o_Y;
    logic [CW-1:0] o_Red, o_Green, o_Blue;
    logic [OW-1:0] obs;
    int errors = 0;
    int checks = 0;

    vga_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .CLK_DIV(CD), .HS_POL(HSP), .VS_POL(VSP), .COLOR_W(CW)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .i_En(i_En), .i_Mode(i_Mode), .i_ColorSel(i_ColorSel),
        .o_PixEn(o_PixEn), .o_Hsync(o_Hsync), .o_Vsync(o_Vsync), .o_Blank_n(o_Blank_n),
        .o_Frame(o_Frame), .o_X(o_X), .o_Y(o_Y), .o_Red(o_Red), .o_Green(o_Green), .o_Blue(o_Blue)
    );

    always #5 Clk = ~Clk;
    assign obs = {o_Hsync, o_Vsync, o_Blank_n, o_Frame, o_X, o_Y, o_Red, o_Green, o_Blue};

    function automatic logic [3*CW-1:0] ref_rgb(input int h, input int v, input int mode, input int col);
        logic [CW-1:0] fs, r, g, b;
        logic [2:0] bars [8];
        int idx;
        fs = {CW{1'b1}};
        r = '0; g = '0; b = '0;
        bars = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
        if (h < HA && v < VA) begin
            case (mode)
                0: case (col)
                    0: r = fs;
                    1: g = fs;
                    2: b = fs;
                    default: begin r = fs; g = fs; b = fs; end
                endcase
                1: begin
                    idx = h / (HA / 8);
                    if (idx > 7) idx = 7;
                    r = bars[idx][2] ? fs : '0;
                    g = bars[idx][1] ? fs : '0;
                    b = bars[idx][0] ? fs : '0;
                end
                2: if (((h / 32) % 2) != ((v / 32) % 2)) begin r = fs; g = fs; b = fs; end
                default: begin
                    r = CW'(h % (1 << CW));
                    g = CW'(v % (1 << CW));
                    b = CW'((h + v) % (1 << CW));
                end
            endcase
        end
        return {r, g, b};
    endfunction

    function automatic logic [OW-1:0] ref_pixel(input int h, input int v, input int mode,
                                                input int col, input int lx, input int ly);
        logic hs, vs, act;
        hs  = (h >= HA + HFP && h < HA + HFP + HSY) ? HSP : ~HSP;
        vs  = (v >= VA + VFP && v < VA + VFP + VSY) ? VSP : ~VSP;
        act = (h < HA && v < VA);
        return {hs, vs, act, (h == 0 && v == 0), XW'(lx), YW'(ly), ref_rgb(h, v, mode, col)};
    endfunction

    task automatic test_reset();
        Rst_n = 1'b0; i_En = 1'b1; i_Mode = 2'd3; i_ColorSel = 2'd3;
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if (o_PixEn !== 1'b0) begin errors++; $display("FAIL reset_pixen got=%b exp=0", o_PixEn); end
        checks++;
        if (obs !== IDLE) begin errors++; $display("FAIL reset_outputs got=%h exp=%h", obs, IDLE); end
        @(negedge Clk);
        i_En = 1'b0; Rst_n = 1'b1;
        @(posedge Clk); #1;
        checks++;
        if (obs !== IDLE || o_PixEn !== 1'b0) begin
            errors++; $display("FAIL idle_after_release got=%h exp=%h", obs, IDLE);
        end
    endtask

    // Several frames with random mid-frame mode/colour changes; each frame uses the selection seen at (0,0).
    task automatic test_frames();
        int r1 [NF];
        int r2 [NF];
        int sched [NF] = '{2, 0, 3, 0, 1};
        int pix_n, fmode, fcol, lx, ly, p, h, v, k, off;
        logic [OW-1:0] prev, exp;
        bit pe;
        for (int i = 0; i < NF; i++) begin
            r1[i] = $urandom_range(FCYC / 2, 5);
            r2[i] = $urandom_range(FCYC - 5, FCYC / 2 + 1);
        end
        @(negedge Clk);
        i_Mode = 2'd1; i_ColorSel = 2'($urandom); i_En = 1'b1;
        pix_n = 0; lx = 0; ly = 0; fmode = 0; fcol = 0;
        prev = obs;
        for (int c = 1; c <= NF * FCYC; c++) begin
            @(posedge Clk); #1;
            pe = ((c % CD) == 0);
            checks++;
            if (o_PixEn !== pe) begin errors++; $display("FAIL pixen cyc=%0d got=%b exp=%b", c, o_PixEn, pe); end
            if (pe) begin
                p = pix_n % FRAME; h = p % HT; v = p / HT;
                if (p == 0) begin fmode = int'(i_Mode); fcol = int'(i_ColorSel); end
                if (h < HA && v < VA) begin lx = h; ly = v; end
                exp = ref_pixel(h, v, fmode, fcol, lx, ly);
                checks++;
                if (obs !== exp) begin
                    errors++; $display("FAIL pixel h=%0d v=%0d mode=%0d got=%h exp=%h", h, v, fmode, obs, exp);
                end
                pix_n++;
            end else begin
                checks++;
                if (obs !== prev) begin errors++; $display("FAIL hold cyc=%0d got=%h exp=%h", c, obs, prev); end
            end
            prev = obs;
            if (c >= 2) begin
                k = (c - 2) / FCYC; off = (c - 2) % FCYC;
                if (k < NF && off == r1[k]) begin i_Mode = 2'($urandom); i_ColorSel = 2'($urandom); end
                if (k < NF && off == r2[k]) begin i_Mode = 2'(sched[k]); i_ColorSel = 2'($urandom); end
            end
        end
    endtask

    task automatic test_disable();
        int first;
        @(negedge Clk); i_En = 1'b0;
        @(posedge Clk); #1;
        checks++;
        if (obs !== IDLE || o_PixEn !== 1'b0) begin errors++; $display("FAIL disable_now got=%h exp=%h", obs, IDLE); end
        repeat (10) @(posedge Clk);
        #1;
        checks++;
        if (obs !== IDLE || o_PixEn !== 1'b0) begin errors++; $display("FAIL disable_hold got=%h exp=%h", obs, IDLE); end
        @(negedge Clk); i_Mode = 2'd0; i_ColorSel = 2'd2; i_En = 1'b1;
        first = -1;
        for (int c = 1; c <= 6 && first < 0; c++) begin
            @(posedge Clk); #1;
            if (o_PixEn === 1'b1) first = c;
        end
        checks++;
        if (first != 2) begin errors++; $display("FAIL reenable_latency got=%0d exp=2", first); end
        checks++;
        if (obs !== ref_pixel(0, 0, 0, 2, 0, 0)) begin
            errors++; $display("FAIL reenable_first got=%h exp=%h", obs, ref_pixel(0, 0, 0, 2, 0, 0));
        end
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if (obs !== ref_pixel(1, 0, 0, 2, 1, 0)) begin
            errors++; $display("FAIL reenable_second got=%h exp=%h", obs, ref_pixel(1, 0, 0, 2, 1, 0));
        end
    endtask

    task automatic test_reset_midframe();
        int first;
        repeat (1233) @(posedge Clk);
        #3;
        Rst_n = 1'b0; i_En = 1'b0;
        #1;
        checks++;
        if (obs !== IDLE || o_PixEn !== 1'b0) begin errors++; $display("FAIL async_reset got=%h exp=%h", obs, IDLE); end
        @(negedge Clk); Rst_n = 1'b1;
        repeat (10) @(posedge Clk);
        #1;
        checks++;
        if (obs !== IDLE || o_PixEn !== 1'b0) begin errors++; $display("FAIL reset_idle got=%h exp=%h", obs, IDLE); end
        @(negedge Clk); i_Mode = 2'd3; i_ColorSel = 2'($urandom); i_En = 1'b1;
        first = -1;
        for (int c = 1; c <= 6 && first < 0; c++) begin
            @(posedge Clk); #1;
            if (o_PixEn === 1'b1) first = c;
        end
        checks++;
        if (first != 2 || obs !== ref_pixel(0, 0, 3, 0, 0, 0)) begin
            errors++; $display("FAIL restart_first lat=%0d got=%h exp=%h", first, obs, ref_pixel(0, 0, 3, 0, 0, 0));
        end
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if (obs !== ref_pixel(1, 0, 3, 0, 1, 0)) begin
            errors++; $display("FAIL restart_second got=%h exp=%h", obs, ref_pixel(1, 0, 3, 0, 1, 0));
        end
        repeat (CD * (3 * HT + 5 + 1) - 2 * CD) @(posedge Clk);
        #1;
        checks++;
        if (obs !== ref_pixel(5, 3, 3, 0, 5, 3)) begin
            errors++; $display("FAIL gradient_5_3 got=%h exp=%h", obs, ref_pixel(5, 3, 3, 0, 5, 3));
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_disable();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
